// File: rtl/fir_pkg.sv
// Shared widths, payload types and CSA-tree sizing helpers for the FIR multiplier.
package fir_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned PROD_W = 2 * DATA_W;

   typedef logic [DATA_W-1:0] sample_t;
   typedef logic [DATA_W-1:0] coeff_t;
   typedef logic [PROD_W-1:0] prod_t;

   // Rows left after one 3:2 level: each full triple becomes two rows, leftovers pass through.
   function automatic int unsigned csa_next(input int unsigned n);
      return (n > 2) ? (2 * (n / 3) + (n % 3)) : n;
   endfunction

   function automatic int unsigned csa_rows(input int unsigned n, input int unsigned lvl);
      int unsigned m;
      m = n;
      for (int unsigned i = 0; i < lvl; i++) m = csa_next(m);
      return m;
   endfunction

   function automatic int unsigned csa_levels(input int unsigned n);
      int unsigned m;
      int unsigned l;
      m = n;
      l = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (m > 2) begin
            m = csa_next(m);
            l = l + 1;
         end
      end
      return l;
   endfunction

endpackage

// File: rtl/cla_adder.sv
// Carry-lookahead adder: 4-bit lookahead groups linked by a group-carry chain.
module cla_adder #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   localparam int unsigned NG = (W + 3) / 4;

   logic [W-1:0] w_p;
   logic [W-1:0] w_g;
   logic [NG:0]  w_gc;

   assign w_p     = i_a ^ i_b;
   assign w_g     = i_a & i_b;
   assign w_gc[0] = i_cin;

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int unsigned LO = 4 * gi;
      localparam int unsigned NB = ((W - LO) < 4) ? (W - LO) : 4;

      // w_pre_*[k] spans bits LO..LO+k-1 of the group, so bit k's carry needs only the group carry-in.
      logic [NB-1:0] w_pre_g;
      logic [NB-1:0] w_pre_p;
      logic          w_grp_g;
      logic          w_grp_p;

      always_comb begin
         logic v_g;
         logic v_p;
         v_g     = 1'b0;
         v_p     = 1'b1;
         w_pre_g = '0;
         w_pre_p = '0;
         for (int unsigned k = 0; k < NB; k++) begin
            w_pre_g[k] = v_g;
            w_pre_p[k] = v_p;
            v_g = w_g[LO+k] | (w_p[LO+k] & v_g);
            v_p = w_p[LO+k] & v_p;
         end
         w_grp_g = v_g;
         w_grp_p = v_p;
      end

      for (genvar k = 0; k < NB; k++) begin : g_bit
         assign o_sum[LO+k] = w_p[LO+k] ^ (w_pre_g[k] | (w_pre_p[k] & w_gc[gi]));
      end

      assign w_gc[gi+1] = w_grp_g | (w_grp_p & w_gc[gi]);
   end

   assign o_cout = w_gc[NG];

endmodule

// File: rtl/fir_mult.sv
// Two-stage pipelined tap multiplier: partial products + CSA tree, then CLA final add.
// Define FIR_MULT_SIGNED_EN for two's-complement operands (Baugh-Wooley sign handling).
module fir_mult
   import fir_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   sample,
   input  logic [WIDTH-1:0]   coeff,
   output logic               out_valid,
   output logic [2*WIDTH-1:0] mult_out
);

   localparam int unsigned PW = 2 * WIDTH;
`ifdef FIR_MULT_SIGNED_EN
   localparam int unsigned NPP = WIDTH + 1;
`else
   localparam int unsigned NPP = WIDTH;
`endif
   localparam int unsigned NLVL  = csa_levels(NPP);
   localparam int unsigned NLAST = csa_rows(NPP, NLVL);

   logic [PW-1:0] w_pp [NPP];
   logic [PW-1:0] w_csa_sum;
   logic [PW-1:0] w_csa_carry;
   logic [PW-1:0] w_cla_sum;
   logic          w_unused_cout;

   logic [PW-1:0] r_s1_sum;
   logic [PW-1:0] r_s1_carry;
   logic          r_s1_valid;
   logic [PW-1:0] r_mult_out;
   logic          r_out_valid;

`ifdef FIR_MULT_SIGNED_EN
   // Baugh-Wooley: invert terms pairing exactly one sign bit, then add 2^W + 2^(2W-1).
   always_comb begin
      logic [PW-1:0] v_row;
      v_row = '0;
      w_pp  = '{default: '0};
      for (int unsigned i = 0; i < WIDTH; i++) begin
         v_row = '0;
         for (int unsigned j = 0; j < WIDTH; j++) begin
            v_row[j] = (sample[j] & coeff[i]) ^ ((i == WIDTH - 1) != (j == WIDTH - 1));
         end
         w_pp[i] = v_row << i;
      end
      w_pp[WIDTH] = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
   end
`else
   always_comb begin
      w_pp = '{default: '0};
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_pp[i] = coeff[i] ? (PW'(sample) << i) : '0;
      end
   end
`endif

   // Carry-save tree: every level folds row triples into sum/carry pairs until two rows remain.
   for (genvar l = 0; l <= NLVL; l++) begin : g_lvl
      localparam int unsigned N = csa_rows(NPP, l);
      logic [PW-1:0] w_row [N];

      if (l == 0) begin : g_src
         for (genvar k = 0; k < N; k++) begin : g_cp
            assign w_row[k] = w_pp[k];
         end
      end else begin : g_csa
         localparam int unsigned NP = csa_rows(NPP, l - 1);
         localparam int unsigned NT = NP / 3;
         for (genvar k = 0; k < NT; k++) begin : g_fa
            assign w_row[2*k] = g_lvl[l-1].w_row[3*k] ^ g_lvl[l-1].w_row[3*k+1]
                              ^ g_lvl[l-1].w_row[3*k+2];
            assign w_row[2*k+1] = ((g_lvl[l-1].w_row[3*k]   & g_lvl[l-1].w_row[3*k+1])
                                 | (g_lvl[l-1].w_row[3*k]   & g_lvl[l-1].w_row[3*k+2])
                                 | (g_lvl[l-1].w_row[3*k+1] & g_lvl[l-1].w_row[3*k+2])) << 1;
         end
         for (genvar k = 3 * NT; k < NP; k++) begin : g_pass
            assign w_row[2*NT+k-3*NT] = g_lvl[l-1].w_row[k];
         end
      end
   end

   assign w_csa_sum = g_lvl[NLVL].w_row[0];
   if (NLAST >= 2) begin : g_two_rows
      assign w_csa_carry = g_lvl[NLVL].w_row[1];
   end else begin : g_one_row
      assign w_csa_carry = '0;
   end

   // Final add; the product always fits PW bits so the carry-out is discarded.
   cla_adder #(
      .W (PW)
   ) u_cla (
      .i_a    (r_s1_sum),
      .i_b    (r_s1_carry),
      .i_cin  (1'b0),
      .o_sum  (w_cla_sum),
      .o_cout (w_unused_cout)
   );

   // Stages load every cycle; only the valid bit marks which results matter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_sum    <= '0;
         r_s1_carry  <= '0;
         r_s1_valid  <= 1'b0;
         r_mult_out  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_s1_sum    <= w_csa_sum;
         r_s1_carry  <= w_csa_carry;
         r_s1_valid  <= in_valid;
         r_mult_out  <= w_cla_sum;
         r_out_valid <= r_s1_valid;
      end
   end

   assign mult_out  = r_mult_out;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fir_mult.sv
// Scoreboard bench for fir_mult: expected products are queued with their due cycle on issue.
module tb_fir_mult;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  sample;
   logic [7:0]  coeff;
   logic        out_valid;
   logic [15:0] mult_out;

   typedef struct {
      int unsigned due;
      logic [15:0] val;
   } exp_t;

   exp_t        q[$];
   exp_t        m_e;
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   fir_mult #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .sample    (sample),
      .coeff     (coeff),
      .out_valid (out_valid),
      .mult_out  (mult_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference product computed behaviourally from the operands.
   function automatic logic [15:0] model(input logic [7:0] s, input logic [7:0] c);
`ifdef FIR_MULT_SIGNED_EN
      logic signed [15:0] a;
      logic signed [15:0] b;
      a = {{8{s[7]}}, s};
      b = {{8{c[7]}}, c};
      return 16'(a * b);
`else
      return 16'({8'd0, s} * {8'd0, c});
`endif
   endfunction

   // Output monitor: every out_valid must match the head of the queue on its due cycle.
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due < cyc) begin
         n_tests++;
         n_fail++;
         $display("FAIL missing_output: cycle %0d had no out_valid, required value %0d due at cycle %0d",
                  cyc, q[0].val, q[0].due);
         void'(q.pop_front());
      end
      if (out_valid === 1'b1) begin
         n_tests++;
         if (q.size() == 0 || q[0].due != cyc) begin
            n_fail++;
            $display("FAIL unexpected_valid: cycle %0d got out_valid=1 mult_out=%0d, required out_valid=0",
                     cyc, mult_out);
         end else begin
            m_e = q.pop_front();
            if (mult_out !== m_e.val) begin
               n_fail++;
               $display("FAIL product: cycle %0d got mult_out=0x%04h, required 0x%04h",
                        cyc, mult_out, m_e.val);
            end
         end
      end
   end

   task automatic issue(input logic [7:0] s, input logic [7:0] c, input logic [15:0] ex);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      sample   = s;
      coeff    = c;
      q.push_back('{due: cyc + 2, val: ex});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         sample   = 8'($urandom_range(0, 255));
         coeff    = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 10) begin
         idle(1);
         budget++;
      end
      idle(1);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results still pending, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      sample   = 8'd3;
      coeff    = 8'd5;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_tests += 2;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: cycle %0d got out_valid=%b, required 0", i, out_valid);
         end
         if (mult_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: cycle %0d got mult_out=%0d, required 0", i, mult_out);
         end
      end
      rst_n = 1'b1;
      q.push_back('{due: cyc + 2, val: 16'd15});
      drain();
   endtask

   task automatic test_directed();
      issue(8'd0, 8'd0, 16'd0);
      issue(8'd3, 8'd5, 16'd15);
      issue(8'd3, 8'd5, 16'd15);
      issue(8'd5, 8'd2, 16'd10);
      drain();
   endtask

   task automatic test_extremes();
`ifdef FIR_MULT_SIGNED_EN
      issue(8'd255, 8'd255, 16'd1);
      issue(8'd255, 8'd1,   16'hFFFF);
      issue(8'd1,   8'd255, 16'hFFFF);
      issue(8'd0,   8'd255, 16'd0);
      issue(8'd128, 8'd2,   16'hFF00);
`else
      issue(8'd255, 8'd255, 16'd65025);
      issue(8'd255, 8'd1,   16'd255);
      issue(8'd1,   8'd255, 16'd255);
      issue(8'd0,   8'd255, 16'd0);
      issue(8'd128, 8'd2,   16'd256);
`endif
      drain();
   endtask

   task automatic test_bubbles();
      issue(8'd7, 8'd9, 16'd63);
      idle(1);
      issue(8'd12, 8'd12, 16'd144);
      drain();
   endtask

   task automatic test_mid_reset();
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      sample   = 8'd10;
      coeff    = 8'd10;
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) rst_n = 1'b1;
         n_tests++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: step %0d got out_valid=%b mult_out=%0d, required out_valid=0",
                     i, out_valid, mult_out);
         end
      end
      issue(8'd6, 8'd7, 16'd42);
      drain();
   endtask

`ifdef FIR_MULT_SIGNED_EN
   task automatic test_signed();
      issue(8'hFD, 8'd5,   16'hFFF1);
      issue(8'h80, 8'h80,  16'd16384);
      issue(8'd127, 8'hFF, 16'hFF81);
      drain();
   endtask
`endif

   task automatic test_back_to_back();
      logic [7:0] s;
      logic [7:0] c;
      for (int i = 0; i < 40; i++) begin
         s = 8'($urandom_range(0, 255));
         c = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) begin
            issue(s, c, model(s, c));
         end else begin
            idle(1);
         end
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_extremes();
      test_bubbles();
      test_mid_reset();
`ifdef FIR_MULT_SIGNED_EN
      test_signed();
`endif
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
